// File: rtl/soc_system_pll_reset_sequencer.sv
// soc_system_pll_reset_sequencer
//
// Reset sequencer for the SDRAM PLL. It runs on the free-running reference
// clock and pulses the PLL reset. It then waits for lock and qualifies lock
// over a stability window before it releases the downstream reset. Lock loss
// in RUN, or no lock within the timeout, re-asserts the downstream reset and
// re-pulses the PLL.
//
// Ports:
//   clk        free-running reference clock (never a PLL output)
//   rst        synchronous active-high reset
//   locked_in  PLL locked, asynchronous to clk (2-flop synchronized)
//   pll_rst    reset to the PLL, active-high, registered
//   reset_out  downstream reset, active-high, registered
//   ready      high only in RUN, registered
//   lock_lost  one-cycle pulse when lock drops in RUN
//   timeout    one-cycle pulse when WAIT_LOCK expires
//   loss_count saturating count of lock_lost events (cleared only by rst)
//   state      RELOCK=0, WAIT_LOCK=1, STABILIZE=2, RUN=3

module soc_system_pll_reset_sequencer #(
   parameter int PLL_RST_CYCLES = 16,
   parameter int STABLE_CYCLES  = 1024,
   parameter int LOCK_TIMEOUT   = 65536,
   parameter int CNT_W          = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             locked_in,
   output logic             pll_rst,
   output logic             reset_out,
   output logic             ready,
   output logic             lock_lost,
   output logic             timeout,
   output logic [CNT_W-1:0] loss_count,
   output logic [1:0]       state
);

   localparam int MAX_A   = (PLL_RST_CYCLES > STABLE_CYCLES) ? PLL_RST_CYCLES : STABLE_CYCLES;
   localparam int MAX_CYC = (MAX_A > LOCK_TIMEOUT) ? MAX_A : LOCK_TIMEOUT;
   localparam int CTR_W   = $clog2(MAX_CYC + 1);

   // The counter holds "cycles remaining minus one" and the state advances
   // when it reads zero, so the entry edge counts as the first cycle of the
   // new state. The reset cycles do not count as part of the PLL pulse, so
   // the reset value is one larger than the in-operation RELOCK reload.
   // This holds pll_rst high for exactly PLL_RST_CYCLES cycles after rst.
   localparam logic [CTR_W-1:0] LOAD_RESET  = CTR_W'(PLL_RST_CYCLES);
   localparam logic [CTR_W-1:0] LOAD_RELOCK = CTR_W'(PLL_RST_CYCLES - 1);
   localparam logic [CTR_W-1:0] LOAD_WAIT   = CTR_W'(LOCK_TIMEOUT - 1);
   localparam logic [CTR_W-1:0] LOAD_STAB   = CTR_W'(STABLE_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_MAX     = '1;

   typedef enum logic [1:0] {
      RELOCK    = 2'd0,
      WAIT_LOCK = 2'd1,
      STABILIZE = 2'd2,
      RUN       = 2'd3
   } state_t;

   state_t           state_q, state_n;
   logic [CTR_W-1:0] cnt_q, cnt_n;
   logic [1:0]       sync_q;
   logic             locked_s;
   logic             lost_n;
   logic             timeout_n;
   logic [CNT_W-1:0] loss_n;

   assign locked_s = sync_q[1];
   assign state    = state_q;

   always_comb begin
      state_n   = state_q;
      cnt_n     = cnt_q;
      lost_n    = 1'b0;
      timeout_n = 1'b0;
      loss_n    = loss_count;
      case (state_q)
         RELOCK: begin
            if (cnt_q == '0) begin
               state_n = WAIT_LOCK;
               cnt_n   = LOAD_WAIT;
            end else begin
               cnt_n = cnt_q - CTR_W'(1);
            end
         end
         WAIT_LOCK: begin
            // Lock seen in the final cycle wins over the timeout.
            if (locked_s) begin
               state_n = STABILIZE;
               cnt_n   = LOAD_STAB;
            end else if (cnt_q == '0) begin
               state_n   = RELOCK;
               cnt_n     = LOAD_RELOCK;
               timeout_n = 1'b1;
            end else begin
               cnt_n = cnt_q - CTR_W'(1);
            end
         end
         STABILIZE: begin
            if (!locked_s) begin
               state_n = WAIT_LOCK;
               cnt_n   = LOAD_WAIT;
            end else if (cnt_q == '0) begin
               state_n = RUN;
               cnt_n   = '0;
            end else begin
               cnt_n = cnt_q - CTR_W'(1);
            end
         end
         RUN: begin
            if (!locked_s) begin
               state_n = RELOCK;
               cnt_n   = LOAD_RELOCK;
               lost_n  = 1'b1;
               if (loss_count != CNT_MAX) begin
                  loss_n = loss_count + CNT_W'(1);
               end
            end
         end
         default: begin
            state_n = RELOCK;
            cnt_n   = LOAD_RESET;
         end
      endcase
   end

   // Outputs are registered from the next state so they change on the same
   // edge as the state itself.
   always_ff @(posedge clk) begin
      if (rst) begin
         sync_q     <= 2'b00;
         state_q    <= RELOCK;
         cnt_q      <= LOAD_RESET;
         pll_rst    <= 1'b1;
         reset_out  <= 1'b1;
         ready      <= 1'b0;
         lock_lost  <= 1'b0;
         timeout    <= 1'b0;
         loss_count <= '0;
      end else begin
         sync_q     <= {sync_q[0], locked_in};
         state_q    <= state_n;
         cnt_q      <= cnt_n;
         pll_rst    <= (state_n == RELOCK);
         reset_out  <= (state_n != RUN);
         ready      <= (state_n == RUN);
         lock_lost  <= lost_n;
         timeout    <= timeout_n;
         loss_count <= loss_n;
      end
   end

endmodule

// File: tb/tb_soc_system_pll_reset_sequencer.sv
module tb_soc_system_pll_reset_sequencer;

   localparam int P = 4;
   localparam int S = 8;
   localparam int L = 32;
   localparam int CW = 2;
   localparam int W = 9;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst = 1'b1;
   logic locked_in = 1'b0;
   always #5 clk = ~clk;

   logic          pll_rst, reset_out, ready, lock_lost, timeout;
   logic [CW-1:0] loss_count;
   logic [1:0]    state;
   logic [W-1:0]  dut_vec;

   soc_system_pll_reset_sequencer #(
      .PLL_RST_CYCLES(P),
      .STABLE_CYCLES (S),
      .LOCK_TIMEOUT  (L),
      .CNT_W         (CW)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .locked_in (locked_in),
      .pll_rst   (pll_rst),
      .reset_out (reset_out),
      .ready     (ready),
      .lock_lost (lock_lost),
      .timeout   (timeout),
      .loss_count(loss_count),
      .state     (state)
   );

   assign dut_vec = {state, pll_rst, reset_out, ready, lock_lost, timeout, loss_count};

   int errors = 0;
   int checks = 0;
   int cyc = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // ---------------- reference model ----------------
   // Phases are tracked by elapsed cycles since entry. locked_s at an edge is
   // the locked_in value sampled two edges earlier (a two-entry history).
   int m_phase = 0;
   int m_age = 0;
   int m_losses = 0;
   bit m_lost = 0;
   bit m_to = 0;
   bit hist[$] = '{1'b0, 1'b0};

   task automatic model_edge(input logic r, input logic l);
      bit ls;
      m_lost = 0;
      m_to = 0;
      if (r) begin
         m_phase = 0;
         m_age = 0;
         m_losses = 0;
         hist = '{1'b0, 1'b0};
      end else begin
         ls = hist[0];
         hist.push_back(l);
         void'(hist.pop_front());
         case (m_phase)
            0: if (m_age >= P) begin m_phase = 1; m_age = 1; end else m_age++;
            1: if (ls) begin m_phase = 2; m_age = 1; end
               else if (m_age >= L) begin m_phase = 0; m_age = 1; m_to = 1; end
               else m_age++;
            2: if (!ls) begin m_phase = 1; m_age = 1; end
               else if (m_age >= S) begin m_phase = 3; m_age = 1; end
               else m_age++;
            default: if (!ls) begin
               m_phase = 0;
               m_age = 1;
               m_lost = 1;
               m_losses = (m_losses < 3) ? m_losses + 1 : 3;
            end
         endcase
      end
   endtask

   function automatic logic [W-1:0] model_vec();
      return {2'(m_phase), m_phase == 0, m_phase != 3, m_phase == 3, m_lost, m_to, 2'(m_losses)};
   endfunction

   // ---------------- scoreboard ----------------
   logic [W-1:0] exp_q[$];

   // ---------------- driver ----------------
   task automatic step(input logic r, input logic l);
      logic [W-1:0] e;
      rst = r;
      locked_in = l;
      @(posedge clk);
      model_edge(r, l);
      exp_q.push_back(model_vec());
      #1;
      cyc++;
      e = exp_q.pop_front();
      check($sformatf("scoreboard cyc %0d", cyc), 32'(dut_vec), 32'(e));
   endtask

   task automatic bring_up();
      for (int i = 0; i < 100; i++) begin
         step(1'b0, 1'b1);
         if (ready === 1'b1) break;
      end
      check("bring_up_ready", 32'(ready), 32'd1);
   endtask

   task automatic lose_lock(input int exp_cnt);
      step(1'b0, 1'b0);
      check("ll_pre1_ready", 32'(ready), 32'd1);
      step(1'b0, 1'b0);
      check("ll_pre2_ready", 32'(ready), 32'd1);
      check("ll_pre2_pulse", 32'(lock_lost), 32'd0);
      step(1'b0, 1'b0);
      check("ll_pulse", 32'(lock_lost), 32'd1);
      check("ll_reset_out", 32'(reset_out), 32'd1);
      check("ll_ready", 32'(ready), 32'd0);
      check("ll_pll_rst", 32'(pll_rst), 32'd1);
      check("ll_state", 32'(state), 32'd0);
      check("ll_count", 32'(loss_count), 32'(exp_cnt));
      for (int k = 0; k < 3; k++) begin
         step(1'b0, 1'b0);
         check("ll_pll_hold", 32'(pll_rst), 32'd1);
         check("ll_pulse_end", 32'(lock_lost), 32'd0);
      end
      step(1'b0, 1'b0);
      check("ll_pll_low", 32'(pll_rst), 32'd0);
      check("ll_wait_state", 32'(state), 32'd1);
   endtask

   // ---------------- power-up vector table ----------------
   typedef struct {
      logic       rst;
      logic       lock;
      logic [1:0] st;
      logic       pll;
      logic       rout;
      logic       rdy;
      logic       pulses;
      logic [1:0] cnt;
   } vec_t;

   vec_t tbl[27];

   initial begin
      int c;
      // Reset 3 cycles; locked_in rises during cycle 10 (first sampled at
      // edge 11). WAIT_LOCK from 5, STABILIZE from 13, RUN from 21.
      for (int i = 0; i < 27; i++) begin
         c = i - 2;
         tbl[i].rst    = (c <= 0);
         tbl[i].lock   = (c >= 11);
         tbl[i].st     = (c <= 4) ? 2'd0 : (c <= 12) ? 2'd1 : (c <= 20) ? 2'd2 : 2'd3;
         tbl[i].pll    = (c <= 4);
         tbl[i].rout   = (c <= 20);
         tbl[i].rdy    = (c >= 21);
         tbl[i].pulses = 1'b0;
         tbl[i].cnt    = 2'd0;
      end

      for (int i = 0; i < 27; i++) begin
         step(tbl[i].rst, tbl[i].lock);
         check($sformatf("pu_state row %0d", i), 32'(state), 32'(tbl[i].st));
         check($sformatf("pu_pll_rst row %0d", i), 32'(pll_rst), 32'(tbl[i].pll));
         check($sformatf("pu_reset_out row %0d", i), 32'(reset_out), 32'(tbl[i].rout));
         check($sformatf("pu_ready row %0d", i), 32'(ready), 32'(tbl[i].rdy));
         check($sformatf("pu_pulses row %0d", i), 32'({lock_lost, timeout}), 32'({2{tbl[i].pulses}}));
         check($sformatf("pu_count row %0d", i), 32'(loss_count), 32'(tbl[i].cnt));
      end

      // Lock loss and saturation: counts 1, 2, 3, 3, 3.
      for (int i = 1; i <= 5; i++) begin
         lose_lock((i < 3) ? i : 3);
         if (i < 5) bring_up();
      end

      // Glitch in STABILIZE.
      begin
         int n = 0;
         while (state !== 2'd2 && n < 20) begin
            step(1'b0, 1'b1);
            n++;
         end
         check("gl_reach_stab", 32'(state), 32'd2);
      end
      step(1'b0, 1'b1);
      step(1'b0, 1'b0);
      step(1'b0, 1'b1);
      check("gl_still_stab", 32'(state), 32'd2);
      step(1'b0, 1'b1);
      check("gl_back_wait", 32'(state), 32'd1);
      step(1'b0, 1'b1);
      check("gl_restab", 32'(state), 32'd2);
      for (int k = 4; k <= 10; k++) step(1'b0, 1'b1);
      check("gl_ready_low", 32'(ready), 32'd0);
      step(1'b0, 1'b1);
      check("gl_ready_high", 32'(ready), 32'd1);
      check("gl_reset_out", 32'(reset_out), 32'd0);

      // Mid-operation reset from RUN.
      step(1'b1, 1'b1);
      check("mr_state", 32'(state), 32'd0);
      check("mr_pll_rst", 32'(pll_rst), 32'd1);
      check("mr_reset_out", 32'(reset_out), 32'd1);
      check("mr_ready", 32'(ready), 32'd0);
      check("mr_count", 32'(loss_count), 32'd0);

      // Timeout with lock held low: WAIT from 5, timeouts at 37 and 73.
      for (int c2 = 1; c2 <= 80; c2++) begin
         step(1'b0, 1'b0);
         check($sformatf("to_pulse c%0d", c2), 32'(timeout), 32'(c2 == 37 || c2 == 73));
         check($sformatf("to_pll c%0d", c2), 32'(pll_rst),
               32'(c2 <= 4 || (c2 >= 37 && c2 <= 40) || (c2 >= 73 && c2 <= 76)));
         check($sformatf("to_count c%0d", c2), 32'(loss_count), 32'd0);
      end

      // Randomized lock behaviour with occasional reset, against the model.
      begin
         int run_len = 0;
         logic lv = 1'b0;
         for (int i = 0; i < 3000; i++) begin
            if (run_len == 0) begin
               lv = 1'($urandom_range(0, 1));
               run_len = $urandom_range(1, 60);
            end
            run_len--;
            step(1'($urandom_range(0, 299) == 0), lv);
            if (lock_lost === 1'b1 && timeout === 1'b1) check("rand_pulse_overlap", 32'd1, 32'd0);
         end
      end

      check("exp_q_drained", 32'(exp_q.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
